// File: rtl/seg7_ctrl.sv
// seg7_ctrl: control and scheduling front-end for the 7-segment display driver.
//
// Holds the DATA / PTLE / CTRL registers behind a small CPU bus, generates
// the scan phase and blink timebase, arbitrates display ownership between the
// CPU and a debug source, and emits a one-cycle update strobe whenever the
// registered display outputs (data/point/LES) take a new value.
//
// Optional build macro: SEG7_CTRL_DBG_TIMEOUT_EN
//   defined   - a debug grant expires after DBG_HOLD blink toggles and the
//               arbiter sits in LOCKOUT until dbg_req is seen low; STAT[3]=lockout
//   undefined - grants last as long as dbg_req; STAT[3] reads 0
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_we, cpu_re             single-cycle write / read strobes
//   cpu_addr                   0 DATA, 1 PTLE, 2 CTRL, 3 STAT (read-only)
//   cpu_wdata, cpu_be          write data and byte enables
//   cpu_rdata, cpu_ack         read data (valid while ack) and completion pulse
//   dbg_req, dbg_data, dbg_gnt debug ownership request, value, grant
//   data, point, LES           registered display value, decimal points, blank mask
//   clkScan, clkBlink          scan phase and blink level
//   update                     one-cycle strobe: displayed value changed
module seg7_ctrl #(
   parameter int unsigned SCAN_DIV  = 1024,
   parameter int unsigned BLINK_DIV = 128,
   parameter int unsigned DBG_HOLD  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_we,
   input  logic        cpu_re,
   input  logic [1:0]  cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_be,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   input  logic        dbg_req,
   input  logic [31:0] dbg_data,
   output logic        dbg_gnt,
   output logic [31:0] data,
   output logic [7:0]  point,
   output logic [7:0]  LES,
   output logic [1:0]  clkScan,
   output logic        clkBlink,
   output logic        update
);

   if (SCAN_DIV < 2 || BLINK_DIV < 1 || DBG_HOLD < 1) begin : g_bad_param
      $error("seg7_ctrl: SCAN_DIV must be >= 2, BLINK_DIV and DBG_HOLD >= 1");
   end

   localparam int unsigned   SW        = $clog2(SCAN_DIV);
   localparam int unsigned   BW        = $clog2(BLINK_DIV + 1);
   localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

`ifdef SEG7_CTRL_DBG_TIMEOUT_EN
   localparam int unsigned   HW        = $clog2(DBG_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(DBG_HOLD - 1);
   typedef enum logic [1:0] {IDLE, GRANT, LOCKOUT} state_t;
   logic [HW-1:0] hold_cnt;
   logic          lockout;
`else
   typedef enum logic {IDLE, GRANT} state_t;
   logic          lockout;
   assign lockout = 1'b0;
`endif

   state_t        state;
   logic          run;
   logic [SW-1:0] scan_cnt;
   logic [BW-1:0] blink_cnt;
   logic          blink_q;
   logic          scan_wrap;
   logic          blink_wrap;
   logic [31:0]   data_r;
   logic [31:0]   ptle_r;
   logic [1:0]    ctrl_r;
   logic [31:0]   rd_mux;
   logic [31:0]   nxt_data;
   logic [7:0]    nxt_point;
   logic [7:0]    nxt_les;

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [3:0]  be);
      logic [31:0] r;
      r = old;
      for (int unsigned i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // Reset release is taken through one flop; counters start on the edge after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run <= 1'b0;
      else        run <= 1'b1;
   end

   // ---------------- timebase ----------------
   assign scan_wrap  = run && (scan_cnt == SCAN_MAX);
   assign blink_wrap = scan_wrap && (blink_cnt == BLINK_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         blink_cnt <= '0;
         clkScan   <= '0;
         blink_q   <= 1'b0;
      end else if (run) begin
         if (scan_wrap) begin
            scan_cnt <= '0;
            clkScan  <= clkScan + 2'd1;
            if (blink_wrap) begin
               blink_cnt <= '0;
               blink_q   <= ~blink_q;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
      end
   end

   assign clkBlink = blink_q | ctrl_r[1];

   // ---------------- register file / bus ----------------
   always_comb begin
      rd_mux = '0;
      case (cpu_addr)
         2'd0:    rd_mux = data_r;
         2'd1:    rd_mux = ptle_r;
         2'd2:    rd_mux = {30'b0, ctrl_r};
         default: rd_mux = {28'b0, lockout, dbg_gnt, clkBlink, clkScan[0]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r    <= '0;
         ptle_r    <= 32'h0000_FF00;
         ctrl_r    <= 2'b01;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         cpu_ack   <= cpu_we | cpu_re;
         cpu_rdata <= (cpu_we | cpu_re) ? rd_mux : '0;
         if (cpu_we) begin
            case (cpu_addr)
               2'd0:    data_r <= merge(data_r, cpu_wdata, cpu_be);
               2'd1:    ptle_r <= merge(ptle_r, cpu_wdata, cpu_be);
               2'd2:    if (cpu_be[0]) ctrl_r <= cpu_wdata[1:0];
               default: ;
            endcase
         end
      end
   end

   // ---------------- arbiter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         dbg_gnt <= 1'b0;
`ifdef SEG7_CTRL_DBG_TIMEOUT_EN
         hold_cnt <= '0;
         lockout  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // A coincident CPU write takes the cycle; grant follows next edge.
               if (dbg_req && !cpu_we) begin
                  state   <= GRANT;
                  dbg_gnt <= 1'b1;
`ifdef SEG7_CTRL_DBG_TIMEOUT_EN
                  hold_cnt <= '0;
`endif
               end
            end
            GRANT: begin
               if (!dbg_req) begin
                  state   <= IDLE;
                  dbg_gnt <= 1'b0;
               end
`ifdef SEG7_CTRL_DBG_TIMEOUT_EN
               else if (blink_wrap) begin
                  if (hold_cnt == HOLD_MAX) begin
                     state   <= LOCKOUT;
                     dbg_gnt <= 1'b0;
                     lockout <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
`endif
            end
`ifdef SEG7_CTRL_DBG_TIMEOUT_EN
            LOCKOUT: begin
               if (!dbg_req) begin
                  state   <= IDLE;
                  lockout <= 1'b0;
               end
            end
`endif
            default: begin
               state   <= IDLE;
               dbg_gnt <= 1'b0;
            end
         endcase
      end
   end

   // ---------------- output mux ----------------
   always_comb begin
      nxt_data  = data_r;
      nxt_point = ptle_r[7:0];
      nxt_les   = ptle_r[15:8];
      if (dbg_gnt) begin
         nxt_data  = dbg_data;
         nxt_point = 8'h00;
         nxt_les   = 8'h00;
      end else if (!ctrl_r[0]) begin
         nxt_point = 8'h00;
         nxt_les   = 8'hFF;
      end
   end

   // update rises together with the new pattern so the shifter reloads it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data   <= '0;
         point  <= '0;
         LES    <= '1;
         update <= 1'b0;
      end else begin
         data   <= nxt_data;
         point  <= nxt_point;
         LES    <= nxt_les;
         update <= {nxt_data, nxt_point, nxt_les} != {data, point, LES};
      end
   end

endmodule
